// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-S25 pipeline front end.
//   - instruction width and opcode constants used by fetch/decode
//   - fetch_state_t: fetch FSM states
//   - isHalt(): opcode test for HLT
package wisc_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    BUF   = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  function automatic logic isHalt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == OP_HLT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture instrIn/pcPlus2In and mark valid
//   flush         : drop the held instruction (valid <= 0), data kept
//   instrIn       : instruction to capture
//   pcPlus2In     : fetch address + 2 of that instruction
//   valid         : register holds a live instruction
//   instr/pcPlus2 : held fields
// Priority: rst > flush > load; with neither flush nor load the
// contents hold (decode stall).
module if_id_reg
  import wisc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [15:0]        pcPlus2In,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [15:0]        pcPlus2
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= '0;
      pcPlus2 <= '0;
    end else if (flush) begin
      valid   <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instrIn;
      pcPlus2 <= pcPlus2In;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests instruction memory and
// loads the IF/ID register.
//   clk, rst        : clock, synchronous active-high reset
//   imem_req/addr   : fetch request and byte address (addr == pc)
//   imem_ready/rdata: memory response for the current address
//   stall           : decode hazard, IF/ID must hold
//   redirect/_pc    : taken branch from downstream, flush and refetch
//   pc              : current fetch PC
//   if_id_*         : IF/ID register outputs
//   halted          : fetch stopped after delivering HLT
// A response arriving while decode is stalled is parked in a one-entry
// skid buffer (state BUF); the buffer is only meaningful in BUF, so
// leaving BUF by any path implicitly invalidates it.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)(
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [15:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  output logic [15:0]        pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [15:0]        if_id_pc_plus2,
  output logic               halted
);

  localparam logic [15:0] RESET_PC_AL = RESET_PC & 16'hFFFE;

  fetch_state_t       state, stateNext;
  logic [15:0]        pcNext, pcPlus2;
  logic [INSTR_W-1:0] skidInstr;
  logic [15:0]        skidPcPlus2;
  logic               skidLoad;
  logic               ifLoad, ifFlush;
  logic [INSTR_W-1:0] ldInstr;
  logic [15:0]        ldPcPlus2;

  // 16-bit add wraps naturally (FFFE + 2 = 0000).
  assign pcPlus2 = pc + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC_AL;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skidInstr   <= '0;
      skidPcPlus2 <= '0;
    end else if (skidLoad) begin
      skidInstr   <= imem_rdata;
      skidPcPlus2 <= pcPlus2;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    skidLoad  = 1'b0;
    ifLoad    = 1'b0;
    ifFlush   = 1'b0;
    ldInstr   = imem_rdata;
    ldPcPlus2 = pcPlus2;
    if (redirect) begin
      // Redirect beats everything: any response this cycle and the skid
      // entry are dropped, and the halt is cleared by returning to FETCH.
      stateNext = FETCH;
      pcNext    = redirect_pc & 16'hFFFE;
      ifFlush   = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            pcNext = pcPlus2;
            if (stall) begin
              skidLoad  = 1'b1;
              stateNext = BUF;
            end else begin
              ifLoad = 1'b1;
              if (isHalt(imem_rdata)) stateNext = HALT;
            end
          end else if (!stall) begin
            ifFlush = 1'b1;  // bubble
          end
        end
        BUF: begin
          if (!stall) begin
            ifLoad    = 1'b1;
            ldInstr   = skidInstr;
            ldPcPlus2 = skidPcPlus2;
            stateNext = isHalt(skidInstr) ? HALT : FETCH;
          end
        end
        HALT: begin
          if (!stall) ifFlush = 1'b1;
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  if_id_reg uIfId (
    .clk       (clk),
    .rst       (rst),
    .load      (ifLoad),
    .flush     (ifFlush),
    .instrIn   (ldInstr),
    .pcPlus2In (ldPcPlus2),
    .valid     (if_id_valid),
    .instr     (if_id_instr),
    .pcPlus2   (if_id_pc_plus2)
  );

  // No request in the reset cycle, regardless of the pre-reset state.
  assign imem_req  = !rst && (state == FETCH);
  assign imem_addr = pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, stall, redirect;
  logic [15:0] imem_addr, imem_rdata, redirect_pc, pc;
  logic        if_id_valid, halted;
  logic [15:0] if_id_instr, if_id_pc_plus2;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc_plus2(if_id_pc_plus2), .halted(halted)
  );

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the stage as "PC + at most one parked instruction +
  // a halted flag". Fetching happens only when nothing is parked and not
  // halted.
  logic [15:0] mPc, mInstr, mP2;
  logic        mValid, mHalted, mKnown = 1'b0;
  logic [31:0] pend[$];

  task automatic modelStep(input logic r, rd, input logic [15:0] rpc,
                           input logic rdy, input logic [15:0] rdat, input logic stl);
    logic [31:0] w;
    if (r) begin
      mKnown = 1'b1; mPc = 16'h0000; mValid = 1'b0; mInstr = 16'h0000;
      mP2 = 16'h0000; mHalted = 1'b0; pend.delete();
    end else if (!mKnown) begin
      // state not yet defined
    end else if (rd) begin
      mPc = {rpc[15:1], 1'b0}; mValid = 1'b0; mHalted = 1'b0; pend.delete();
    end else if (pend.size() != 0) begin
      if (!stl) begin
        w = pend.pop_front();
        mValid = 1'b1; mInstr = w[31:16]; mP2 = w[15:0];
        mHalted = (w[31:28] == 4'hF);
      end
    end else if (mHalted) begin
      if (!stl) mValid = 1'b0;
    end else if (rdy) begin
      w = {rdat, 16'(mPc + 16'd2)};
      mPc = mPc + 16'd2;
      if (stl) pend.push_back(w);
      else begin
        mValid = 1'b1; mInstr = w[31:16]; mP2 = w[15:0];
        mHalted = (w[31:28] == 4'hF);
      end
    end else if (!stl) begin
      mValid = 1'b0;
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance model.
  task automatic cyc(input logic r, rd, input logic [15:0] rpc,
                     input logic rdy, input logic [15:0] rdat, input logic stl);
    rst = r; redirect = rd; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rdat; stall = stl;
    @(negedge clk);
    if (mKnown) begin
      chk("imem_req", {15'd0, imem_req}, {15'd0, !r && !mHalted && pend.size() == 0});
      chk("imem_addr", imem_addr, mPc);
      chk("pc", pc, mPc);
      chk("halted", {15'd0, halted}, {15'd0, mHalted});
      chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, mValid});
      chk("if_id_instr", if_id_instr, mInstr);
      chk("if_id_pc_plus2", if_id_pc_plus2, mP2);
    end else begin
      chk("imem_req_rst", {15'd0, imem_req}, 16'd0);
    end
    modelStep(r, rd, rpc, rdy, rdat, stl);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    imem_rdata = '0; stall = 1'b0;
    @(posedge clk); #1;
    // Reset then straight-line fetch.
    cyc(1, 0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 1, 16'h1234, 0);
    chk("first_instr", if_id_instr, 16'h1234);
    cyc(0, 0, 0, 1, 16'h2345, 0);
    chk("second_p2", if_id_pc_plus2, 16'h0004);
    // Stall on a fetch: parked for three stall cycles, delivered after.
    cyc(0, 0, 0, 1, 16'hA123, 1);
    cyc(0, 0, 0, 1, 16'h5555, 1);
    cyc(0, 0, 0, 1, 16'h5555, 1);
    cyc(0, 0, 0, 0, 16'h5555, 0);
    chk("skid_instr", if_id_instr, 16'hA123);
    chk("skid_addr", imem_addr, 16'h0006);
    // Redirect with ready+stall: response dropped, odd target aligned.
    cyc(0, 1, 16'h0041, 1, 16'h7777, 1);
    chk("redir_addr", imem_addr, 16'h0040);
    cyc(0, 0, 0, 0, 16'h0, 0);
    // HLT at 0010, then redirect away.
    cyc(0, 1, 16'h0010, 0, 16'h0, 0);
    cyc(0, 0, 0, 1, 16'hF000, 0);
    chk("hlt_halted", {15'd0, halted}, 16'd1);
    cyc(0, 0, 0, 1, 16'h1111, 0);
    cyc(0, 0, 0, 1, 16'h1111, 0);
    cyc(0, 1, 16'h0020, 1, 16'h1111, 0);
    chk("unhalt_addr", imem_addr, 16'h0020);
    // Wrap at FFFE.
    cyc(0, 1, 16'hFFFE, 0, 16'h0, 0);
    cyc(0, 0, 0, 1, 16'h0000, 0);
    chk("wrap_p2", if_id_pc_plus2, 16'h0000);
    // Reset in the middle of BUF.
    cyc(0, 0, 0, 1, 16'h4321, 1);
    cyc(1, 0, 0, 1, 16'h9999, 1);
    chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
    cyc(0, 0, 0, 1, 16'h3333, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 9) == 0) d[15:12] = 4'hF;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
          16'($urandom), $urandom_range(0, 9) < 7, d, $urandom_range(0, 3) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the WISC-S25 pipeline: owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register whose instruction field feeds the control decoder and register-file read stage. Supports multi-cycle memory responses, decode-stage stalls via a one-entry skid buffer, branch/BR redirects with flush, and stops fetching after HLT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 forced to 0
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; imem_addr valid while high
- imem_addr  out  16  byte address of instruction being fetched (= pc)
- imem_ready  in  1  imem_rdata valid for current imem_addr this cycle; ignored when imem_req=0
- imem_rdata  in  16  instruction word
- stall  in  1  decode hazard: IF/ID must hold its contents
- redirect  in  1  taken B/BR from downstream: flush and refetch
- redirect_pc  in  16  new PC; bit 0 ignored
- pc  out  16  current fetch PC
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_instr  out  16  instruction to decode/control
- if_id_pc_plus2  out  16  address of fetched instruction + 2 (PCS/branch base)
- halted  out  1  fetch stopped on HLT

## Operation
- States: FETCH, BUF, HALT.
- Priority per cycle: rst > redirect > normal operation.
- Reset values: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=16'h0000, if_id_pc_plus2=16'h0000, halted=0, imem_req=0 during reset cycle, skid buffer invalid.
- redirect (any state, stall ignored): pc<=redirect_pc&16'hFFFE; if_id_valid<=0; skid buffer discarded; any imem_ready this cycle discarded; halted<=0; state<=FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & !stall: IF/ID <= {1, rdata, pc+2}; pc<=pc+2; to HALT if rdata[15:12]==4'hF, else stay.
  - ready & stall: rdata and pc+2 captured in skid buffer; pc<=pc+2; IF/ID held; to BUF.
  - !ready & !stall: if_id_valid<=0 (bubble); !ready & stall: IF/ID held.
- BUF: imem_req=0. stall: hold everything. !stall: IF/ID <= buffer; to HALT if buffered opcode 4'hF, else FETCH.
- HALT: imem_req=0, halted=1. !stall: if_id_valid<=0. Leaves only via redirect or rst.
- PC arithmetic modulo 2^16: 16'hFFFE+2 = 16'h0000; if_id_pc_plus2 wraps identically.
- HLT itself is delivered into IF/ID with valid=1; nothing after it is fetched.

## Timing
- Fetch latency: imem_ready in cycle N -> if_id_valid/if_id_instr updated at edge ending N, visible in N+1.
- Throughput: one instruction per cycle with imem_ready held high and stall low.
- Redirect in cycle N: imem_addr=redirect_pc in N+1; earliest new instruction in IF/ID in N+2; IF/ID invalid in N+1.
- stall held k cycles after a buffered fetch: next fetch request issues no earlier than the cycle after stall drops (BUF->FETCH).
- imem protocol: imem_addr stable while imem_req=1 and !imem_ready, except on redirect (abandoned request permitted; memory must answer for current address only).
- halted asserts the cycle after HLT is captured into IF/ID.

## Structure
- Shared package wisc_pkg: opcode constants (OP_HLT=4'hF, OP_B, OP_BR, OP_PCS), instruction width 16, fetch_state_t enum {FETCH, BUF, HALT}.
- One sub-module: if_id_reg (load-enable, flush, valid bit, instr + pc_plus2 fields, sync active-high reset); fetch_unit instantiates it and holds PC, skid buffer and FSM.

## Test plan
- Reset, RESET_PC=16'h0000, imem_ready=1, rdata 16'h1234,16'h2345 -> imem_addr 0000,0002; IF/ID instr 1234 with pc_plus2 0002, then 2345 with 0004, valid every cycle.
- Fetch at pc 0004 returns 16'hA123 with stall=1 for 3 cycles -> IF/ID unchanged, imem_req=0 during stall, A123 with pc_plus2 0006 appears cycle after stall drops, next imem_addr 0006.
- redirect=1, redirect_pc=16'h0041 while imem_ready=1 and stall=1 -> response discarded, if_id_valid=0 next cycle, imem_addr=0040 next cycle, buffer cleared.
- Fetch 16'hF000 at pc 0010 -> IF/ID F000 valid, halted=1, imem_req=0 afterwards, if_id_valid=0 following cycle; redirect to 0020 clears halted and fetches 0020.
- redirect_pc=16'hFFFE, rdata 16'h0000 -> pc_plus2 0000, next imem_addr 0000 (wrap).
- rst asserted mid-BUF -> all outputs at reset values next cycle, fetch restarts at RESET_PC.
